// File: rtl/log_phase_fold_3h.sv
// log_phase_fold_3h: phase generation front end for the log-domain
// trigonometric FLAF expansion. Forms pi*x, 2*pi*x and 3*pi*x in pi/32 steps
// and folds each phase into the first quadrant. Each harmonic gets a 0..16
// LUT index, sign flags and log-of-zero flags.
//
// Ports:
//   clk, rst (async, active high)
//   x_in [X_W]      signed Q1.(X_W-1) sample
//   in_valid/in_ready, out_valid/out_ready  two-stage elastic handshake
//   idx1..idx3 [5]  folded LUT index per harmonic
//   sin_neg, cos_neg, sin_zero, cos_zero [3]  bit k-1 belongs to harmonic k
module log_phase_fold_3h #(
  parameter int X_W   = 16,
  parameter bit ROUND = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [X_W-1:0] x_in,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4:0]     idx1,
  output logic [4:0]     idx2,
  output logic [4:0]     idx3,
  output logic [2:0]     sin_neg,
  output logic [2:0]     cos_neg,
  output logic [2:0]     sin_zero,
  output logic [2:0]     cos_zero
);

  localparam int KW = X_W + 3;
  localparam int SH = X_W - 6;
  localparam logic [KW-1:0] RND = ROUND ? (KW'(1) << (X_W - 7)) : '0;

  // k*x with enough headroom that 3*x plus the rounding offset cannot overflow.
  logic [KW-1:0] x1, x2, x3, s1, s2, s3;
  assign x1 = {{3{x_in[X_W-1]}}, x_in};
  assign x2 = x1 << 1;
  assign x3 = x2 + x1;
  assign s1 = x1 + RND;
  assign s2 = x2 + RND;
  assign s3 = x3 + RND;

  // Bits [SH+5:SH] equal the low 6 bits of the arithmetic right shift by SH,
  // i.e. the phase in pi/32 units taken modulo 2*pi.
  logic unused_bits;
  assign unused_bits = ^{s1[KW-1:SH+6], s1[SH-1:0],
                         s2[KW-1:SH+6], s2[SH-1:0],
                         s3[KW-1:SH+6], s3[SH-1:0]};

  // {idx[4:0], sin_neg, cos_neg, sin_zero, cos_zero}
  function automatic logic [8:0] fold(input logic [5:0] p);
    logic [4:0] idx;
    logic       sn, cn, sz, cz;
    idx = p[4] ? (5'd16 - {1'b0, p[3:0]}) : {1'b0, p[3:0]};
    sn  = p[5];
    cn  = p[5] ^ p[4];
    sz  = (idx == 5'd0);
    cz  = (idx == 5'd16);
    // log of zero carries no sign
    return {idx, sn & ~sz, cn & ~cz, sz, cz};
  endfunction

  logic       v1, v2, adv1, adv2;
  logic [5:0] p1, p2, p3;
  logic [8:0] f1, f2, f3;

  assign adv2      = ~v2 | out_ready;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  assign f1 = fold(p1);
  assign f2 = fold(p2);
  assign f3 = fold(p3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      p1       <= '0;
      p2       <= '0;
      p3       <= '0;
      idx1     <= '0;
      idx2     <= '0;
      idx3     <= '0;
      sin_neg  <= '0;
      cos_neg  <= '0;
      sin_zero <= '0;
      cos_zero <= '0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          p1 <= s1[SH+5:SH];
          p2 <= s2[SH+5:SH];
          p3 <= s3[SH+5:SH];
        end
      end
      if (adv2) begin
        v2 <= v1;
        // Only real samples overwrite the output registers.
        if (v1) begin
          idx1     <= f1[8:4];
          idx2     <= f2[8:4];
          idx3     <= f3[8:4];
          sin_neg  <= {f3[3], f2[3], f1[3]};
          cos_neg  <= {f3[2], f2[2], f1[2]};
          sin_zero <= {f3[1], f2[1], f1[1]};
          cos_zero <= {f3[0], f2[0], f1[0]};
        end
      end
    end
  end

endmodule
